// File: rtl/atomic_counter_reader.sv
// Initiator for the atomic 64-bit counter read: issues req/atomic, gathers LSB then MSB beats,
// and hands the sample to the host over valid/ready. Optional ATOMIC_READER_DELTA_EN adds delta_o.
module atomic_counter_reader #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned TO_W    = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rd_valid_i,
    output logic        rd_ready_o,
    output logic        req_o,
    output logic        atomic_o,
    input  logic        ack_i,
    input  logic [31:0] count_i,
    output logic        data_valid_o,
    input  logic        data_ready_i,
    output logic [63:0] data_o,
`ifdef ATOMIC_READER_DELTA_EN
    output logic [63:0] delta_o,
`endif
    output logic        err_o
);

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StLsb,
        StMsb,
        StDone
    } state_e;

    localparam logic [TO_W-1:0] ToLast = TO_W'(TIMEOUT - 1);

    state_e            state_q, state_d;
    logic [TO_W-1:0]   to_q, to_d;
    logic [63:0]       data_q, data_d;
    logic              err_q, err_d;
    logic              rd_ready_q, rd_ready_d;
    logic              req_q, req_d;
    logic              atomic_q, atomic_d;
    logic              valid_q, valid_d;

    always_comb begin
        state_d = state_q;
        to_d    = to_q;
        data_d  = data_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (rd_valid_i) begin
                    state_d = StReq;
                end
            end
            StReq: begin
                data_d  = '0;
                err_d   = 1'b0;
                state_d = StLsb;
            end
            StLsb: begin
                if (ack_i) begin
                    data_d[31:0] = count_i;
                    state_d      = StMsb;
                end else if (to_q == ToLast) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            StMsb: begin
                if (ack_i) begin
                    data_d[63:32] = count_i;
                    state_d       = StDone;
                end else if (to_q == ToLast) begin
                    err_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end
            StDone: begin
                if (data_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Every state entry starts a fresh wait window.
        if (state_d != state_q) begin
            to_d = '0;
        end

        // Outputs are registered from the next state so they line up with it.
        rd_ready_d = (state_d == StIdle);
        req_d      = (state_d == StReq) || (state_d == StLsb);
        atomic_d   = (state_d == StReq);
        valid_d    = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            to_q       <= '0;
            data_q     <= '0;
            err_q      <= 1'b0;
            rd_ready_q <= 1'b1;
            req_q      <= 1'b0;
            atomic_q   <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            to_q       <= to_d;
            data_q     <= data_d;
            err_q      <= err_d;
            rd_ready_q <= rd_ready_d;
            req_q      <= req_d;
            atomic_q   <= atomic_d;
            valid_q    <= valid_d;
        end
    end

    assign rd_ready_o   = rd_ready_q;
    assign req_o        = req_q;
    assign atomic_o     = atomic_q;
    assign data_valid_o = valid_q;
    assign data_o       = data_q;
    assign err_o        = err_q;

`ifdef ATOMIC_READER_DELTA_EN
    logic [63:0] prev_q, prev_d;
    logic [63:0] delta_q, delta_d;

    always_comb begin
        prev_d  = prev_q;
        delta_d = delta_q;
        // Delta is frozen on DONE entry; error results neither report nor update history.
        if ((state_q != StDone) && (state_d == StDone)) begin
            delta_d = err_d ? 64'd0 : (data_d - prev_q);
        end
        if ((state_q == StDone) && data_ready_i && !err_q) begin
            prev_d = data_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q  <= '0;
            delta_q <= '0;
        end else begin
            prev_q  <= prev_d;
            delta_q <= delta_d;
        end
    end

    assign delta_o = delta_q;
`endif

endmodule

// File: tb/tb_atomic_counter_reader.sv
// Scoreboard bench for atomic_counter_reader with a behavioural snapshotting responder.
// Build with ATOMIC_READER_DELTA_EN to also check delta_o.
module tb_atomic_counter_reader;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd_valid_i;
    logic        rd_ready_o;
    logic        req_o;
    logic        atomic_o;
    logic        ack_i;
    logic [31:0] count_i;
    logic        data_valid_o;
    logic        data_ready_i;
    logic [63:0] data_o;
    logic        err_o;
`ifdef ATOMIC_READER_DELTA_EN
    logic [63:0] delta_o;
`endif

    atomic_counter_reader #(
        .TIMEOUT(16),
        .TO_W   (5)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rd_valid_i  (rd_valid_i),
        .rd_ready_o  (rd_ready_o),
        .req_o       (req_o),
        .atomic_o    (atomic_o),
        .ack_i       (ack_i),
        .count_i     (count_i),
        .data_valid_o(data_valid_o),
        .data_ready_i(data_ready_i),
        .data_o      (data_o),
`ifdef ATOMIC_READER_DELTA_EN
        .delta_o     (delta_o),
`endif
        .err_o       (err_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [63:0] data;
        logic        err;
        logic [63:0] delta;
    } exp_t;

    exp_t exp_q[$];

    // Responder model: live counter, snapshot on atomic, beats after programmable waits.
    logic [63:0] cnt;
    logic [63:0] snap;
    int          pulses;
    int          lsb_wait;
    int          msb_wait;   // negative: never send the MSB beat
    logic [63:0] prev_model;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " rd_ready"}, rd_ready_o, 1);
        check({tag, " req"}, req_o, 0);
        check({tag, " atomic"}, atomic_o, 0);
        check({tag, " data_valid"}, data_valid_o, 0);
        check({tag, " data"}, data_o, 0);
        check({tag, " err"}, err_o, 0);
`ifdef ATOMIC_READER_DELTA_EN
        check({tag, " delta"}, delta_o, 0);
`endif
    endtask

    always begin
        @(negedge clk);
        if (atomic_o && !reset) begin
            snap = cnt;
            cnt  = cnt + 64'(pulses);   // events landing mid-read must not reach the sample
            @(negedge clk);
            repeat (lsb_wait) @(negedge clk);
            ack_i   = 1'b1;
            count_i = snap[31:0];
            @(negedge clk);
            ack_i   = 1'b0;
            count_i = 32'hDEAD_BEEF;
            if (msb_wait >= 0) begin
                repeat (msb_wait) @(negedge clk);
                ack_i   = 1'b1;
                count_i = snap[63:32];
                @(negedge clk);
                ack_i   = 1'b0;
                count_i = 32'hDEAD_BEEF;
            end
        end
    end

    // Monitor: pops one expectation on each rising data_valid_o.
    logic seen_v = 1'b0;
    always begin
        exp_t e;
        @(negedge clk);
        if (data_valid_o && !seen_v) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got %h expected none", data_o);
            end else begin
                e = exp_q.pop_front();
                check("result data", data_o, e.data);
                check("result err", err_o, e.err);
`ifdef ATOMIC_READER_DELTA_EN
                check("result delta", delta_o, e.delta);
`endif
            end
        end
        seen_v = data_valid_o;
    end

    task automatic do_read(input int lw, input int mw, input int exp_lat,
                           input logic [63:0] exp_data, input logic exp_err, input int hold);
        exp_t e;
        int   lat;
        lsb_wait = lw;
        msb_wait = mw;
        e.data  = exp_data;
        e.err   = exp_err;
        e.delta = exp_err ? 64'd0 : (exp_data - prev_model);
        exp_q.push_back(e);
        @(negedge clk);
        check("rd_ready before", rd_ready_o, 1);
        rd_valid_i = 1'b1;
        @(negedge clk);
        rd_valid_i = 1'b0;
        check("req cycle0", req_o, 1);
        check("atomic cycle0", atomic_o, 1);
        check("rd_ready busy", rd_ready_o, 0);
        lat = 0;
        while (!data_valid_o && lat < 100) begin
            @(negedge clk);
            lat++;
            if (!data_valid_o) begin
                check("atomic after cycle0", atomic_o, 0);
                check("req phase", req_o, 64'(lat <= 1 + lw));
            end
        end
        check("latency", 64'(lat), 64'(exp_lat));
        repeat (hold) begin
            check("hold data", data_o, exp_data);
            check("hold valid", data_valid_o, 1);
            check("hold rd_ready", rd_ready_o, 0);
            rd_valid_i = 1'b1;
            @(negedge clk);
        end
        rd_valid_i   = 1'b0;
        data_ready_i = 1'b1;
        @(negedge clk);
        data_ready_i = 1'b0;
        check("valid drop", data_valid_o, 0);
        check("rd_ready back", rd_ready_o, 1);
        check("no stray req", req_o, 0);
        if (!exp_err) prev_model = exp_data;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        rd_valid_i   = 1'b0;
        ack_i        = 1'b0;
        count_i      = 32'h0;
        data_ready_i = 1'b0;
        cnt          = 64'd0;
        pulses       = 0;
        lsb_wait     = 0;
        msb_wait     = 0;
        prev_model   = 64'd0;
        #1;
        check_reset_vals("reset");
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Zero-wait read.
        cnt = 64'h0000_0000_0000_000A;
        do_read(0, 0, 3, 64'h0000_0000_0000_000A, 1'b0, 0);

        // Wrap: snapshot at 0xFFFFFFFF with 3 events during the read.
        cnt    = 64'h0000_0000_FFFF_FFFF;
        pulses = 3;
        do_read(0, 0, 3, 64'h0000_0000_FFFF_FFFF, 1'b0, 0);
        pulses = 0;
        do_read(0, 0, 3, 64'h0000_0001_0000_0002, 1'b0, 0);

        // Stalled beats.
        cnt = 64'h1234_5678_9ABC_DEF0;
        do_read(4, 2, 9, 64'h1234_5678_9ABC_DEF0, 1'b0, 0);

        // MSB timeout, then recovery.
        cnt = 64'hCAFE_0000_0000_0077;
        do_read(0, -1, 18, 64'h0000_0000_0000_0077, 1'b1, 0);
        cnt = 64'h0000_0005_0000_0006;
        do_read(0, 0, 3, 64'h0000_0005_0000_0006, 1'b0, 0);

        // Backpressure for 10 cycles with ignored requests.
        cnt = 64'h0000_00AB_0000_00CD;
        do_read(1, 0, 4, 64'h0000_00AB_0000_00CD, 1'b0, 10);

        // Async reset while waiting in LSB.
        cnt      = 64'h1111_2222_3333_4444;
        lsb_wait = 8;
        msb_wait = 0;
        @(negedge clk);
        rd_valid_i = 1'b1;
        @(negedge clk);
        rd_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check("req in lsb", req_o, 1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("mid-lsb reset");
        @(negedge clk);
        reset      = 1'b0;
        prev_model = 64'd0;
        repeat (15) @(negedge clk);
        check("post reset valid", data_valid_o, 0);
        check("post reset rd_ready", rd_ready_o, 1);

        // Delta sequence: 0x10, timeout, 0x25.
        cnt = 64'h10;
        do_read(0, 0, 3, 64'h10, 1'b0, 0);
        cnt = 64'h99;
        do_read(0, -1, 18, 64'h99, 1'b1, 0);
        cnt = 64'h25;
        do_read(0, 0, 3, 64'h25, 1'b0, 0);

        repeat (2) @(negedge clk);
        check("scoreboard drained", 64'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
